// File: rtl/adder_arbiter_pkg.sv
// Shared constants, grant record and round-robin pick helper for adder_arbiter.
package adder_arbiter_pkg;

    localparam int unsigned N     = 4;
    localparam int unsigned W     = 4;
    localparam int unsigned TAG_W = 2;
    localparam int unsigned CNT_W = 8;

    // Bit positions inside the clock_reset bundle
    localparam int unsigned CLK = 0;
    localparam int unsigned RST = 1;

    typedef struct packed {
        logic             exists;
        logic [TAG_W-1:0] grant;
    } pick_t;

    // First valid requester in the order ptr, ptr+1, ... (mod N).
    // Walks from the farthest offset down so the nearest valid one wins.
    function automatic pick_t rr_pick(input logic [TAG_W-1:0] ptr,
                                      input logic [N-1:0]     valid);
        pick_t            p;
        logic [TAG_W-1:0] idx;
        p.exists = 1'b0;
        p.grant  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = ptr + TAG_W'(i);
            if (valid[idx]) begin
                p.exists = 1'b1;
                p.grant  = idx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/adder_arbiter_adder_unit.sv
// Combinational W-bit wrapping adder over a packed {b, a} operand pair.
module adder_unit
    import adder_arbiter_pkg::*;
(
    input  logic [2*W-1:0] operand_pair,
    output logic [W-1:0]   sum
);

    // Carry out is dropped: the sum wraps modulo 2^W
    always_comb begin
        sum = operand_pair[W-1:0] + operand_pair[2*W-1:W];
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one wrapping adder among N requesters, with a
// one-entry tagged result register and an accepted-transaction counter.
module adder_arbiter
    import adder_arbiter_pkg::*;
(
    input  logic [1:0]       clock_reset,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_a,
    input  logic [N*W-1:0]   req_b,
    output logic [N-1:0]     req_ready,
    output logic             res_valid,
    output logic [W-1:0]     res_sum,
    output logic [TAG_W-1:0] res_tag,
    input  logic             res_ready,
    output logic [CNT_W-1:0] txn_count
);

    logic clk;
    logic rst;
    assign clk = clock_reset[CLK];
    assign rst = clock_reset[RST];

    logic [TAG_W-1:0] ptr_q, ptr_d;
    logic             res_valid_q, res_valid_d;
    logic [W-1:0]     res_sum_q, res_sum_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic [CNT_W-1:0] txn_count_q, txn_count_d;

    pick_t            pick;
    logic             can_accept;
    logic             accept;
    logic [W-1:0]     sel_a;
    logic [W-1:0]     sel_b;
    logic [W-1:0]     add_sum;

    // Grant decision; the result slot is free when empty or being drained
    always_comb begin
        pick       = rr_pick(ptr_q, req_valid);
        can_accept = !res_valid_q | res_ready;
        accept     = pick.exists & can_accept & !rst;
    end

    // One-hot ready to the granted requester only
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[pick.grant] = 1'b1;
        end
    end

    // Steer the granted operand pair into the shared adder
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < N; k++) begin
            if (pick.grant == TAG_W'(k)) begin
                sel_a = req_a[k*W +: W];
                sel_b = req_b[k*W +: W];
            end
        end
    end

    adder_unit u_adder_unit (
        .operand_pair ({sel_b, sel_a}),
        .sum          (add_sum)
    );

    // Next state: accept loads a new result (even while draining), else drain clears valid
    always_comb begin
        ptr_d       = ptr_q;
        res_valid_d = res_valid_q;
        res_sum_d   = res_sum_q;
        res_tag_d   = res_tag_q;
        txn_count_d = txn_count_q;
        if (accept) begin
            res_valid_d = 1'b1;
            res_sum_d   = add_sum;
            res_tag_d   = pick.grant;
            ptr_d       = pick.grant + 2'd1;
            txn_count_d = txn_count_q + CNT_W'(1);
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_tag_q   <= '0;
            txn_count_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            res_valid_q <= res_valid_d;
            res_sum_q   <= res_sum_d;
            res_tag_q   <= res_tag_d;
            txn_count_q <= txn_count_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_tag   = res_tag_q;
    assign txn_count = txn_count_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed, table-driven bench for adder_arbiter.
module tb_adder_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  clock_reset;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic [3:0]  res_sum;
    logic [1:0]  res_tag;
    logic        res_ready;
    logic [7:0]  txn_count;

    int tests;
    int fails;

    assign clock_reset = {rst, clk};

    adder_arbiter dut (
        .clock_reset (clock_reset),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .res_valid   (res_valid),
        .res_sum     (res_sum),
        .res_tag     (res_tag),
        .res_ready   (res_ready),
        .txn_count   (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] a;
        logic [15:0] b;
        logic        rr;
        logic [3:0]  exp_ready;
        logic        exp_rv;
        logic [3:0]  exp_sum;
        logic [1:0]  exp_tag;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b,
                       input logic rr, input logic [3:0] er, input logic erv,
                       input logic [3:0] es, input logic [1:0] et, input logic [7:0] ec);
        vec_t x;
        x.valid = v; x.a = a; x.b = b; x.rr = rr; x.exp_ready = er; x.exp_rv = erv;
        x.exp_sum = es; x.exp_tag = et; x.exp_cnt = ec;
        vecs.push_back(x);
    endtask

    // Drive inputs just after a rising edge, let combinational outputs settle
    task automatic drive(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b,
                         input logic rr);
        req_valid = v; req_a = a; req_b = b; res_ready = rr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string name, input logic rv, input logic [3:0] s,
                           input logic [1:0] t, input logic [7:0] c);
        chk({name, ".res_valid"}, 32'(res_valid), 32'(rv));
        chk({name, ".res_sum"}, 32'(res_sum), 32'(s));
        chk({name, ".res_tag"}, 32'(res_tag), 32'(t));
        chk({name, ".txn_count"}, 32'(txn_count), 32'(c));
    endtask

    initial begin
        tests = 0;
        fails = 0;

        // Sequence: first grant, single requester 2, wraps, drain, grant to 3
        add(4'b1111, 16'h4321, 16'h2222, 1'b1, 4'b0001, 1'b1, 4'd3,  2'd0, 8'd1);
        add(4'b0100, 16'h0300, 16'h0400, 1'b1, 4'b0100, 1'b1, 4'd7,  2'd2, 8'd2);
        add(4'b0001, 16'h0009, 16'h0008, 1'b1, 4'b0001, 1'b1, 4'd1,  2'd0, 8'd3);
        add(4'b0001, 16'h000F, 16'h000F, 1'b1, 4'b0001, 1'b1, 4'd14, 2'd0, 8'd4);
        add(4'b0000, 16'h0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'd14, 2'd0, 8'd4);
        add(4'b1000, 16'h5000, 16'h6000, 1'b1, 4'b1000, 1'b1, 4'd11, 2'd3, 8'd5);
        // All four valid: 0,1,2,3,0,1
        add(4'b1111, 16'h4321, 16'h2222, 1'b1, 4'b0001, 1'b1, 4'd3,  2'd0, 8'd6);
        add(4'b1111, 16'h4321, 16'h2222, 1'b1, 4'b0010, 1'b1, 4'd4,  2'd1, 8'd7);
        add(4'b1111, 16'h4321, 16'h2222, 1'b1, 4'b0100, 1'b1, 4'd5,  2'd2, 8'd8);
        add(4'b1111, 16'h4321, 16'h2222, 1'b1, 4'b1000, 1'b1, 4'd6,  2'd3, 8'd9);
        add(4'b1111, 16'h4321, 16'h2222, 1'b1, 4'b0001, 1'b1, 4'd3,  2'd0, 8'd10);
        add(4'b1111, 16'h4321, 16'h2222, 1'b1, 4'b0010, 1'b1, 4'd4,  2'd1, 8'd11);
        // Requester 1 drops out after the next round: 2,3,0,2
        add(4'b1111, 16'h4321, 16'h2222, 1'b1, 4'b0100, 1'b1, 4'd5,  2'd2, 8'd12);
        add(4'b1111, 16'h4321, 16'h2222, 1'b1, 4'b1000, 1'b1, 4'd6,  2'd3, 8'd13);
        add(4'b1111, 16'h4321, 16'h2222, 1'b1, 4'b0001, 1'b1, 4'd3,  2'd0, 8'd14);
        add(4'b1101, 16'h4321, 16'h2222, 1'b1, 4'b0100, 1'b1, 4'd5,  2'd2, 8'd15);

        // Reset held two cycles with all requesters valid
        rst = 1'b1;
        drive(4'b1111, 16'h4321, 16'h2222, 1'b1);
        tick();
        tick();
        chk("reset.req_ready", 32'(req_ready), 32'h0);
        chk_res("reset", 1'b0, 4'd0, 2'd0, 8'd0);

        // Release reset and walk the vector table
        @(negedge clk);
        rst = 1'b0;
        tick();
        // First table row is re-driven below; the edge just taken already accepted
        // requester 0 with the same inputs, so resync by resetting once more.
        rst = 1'b1;
        tick();
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].rr);
            chk($sformatf("vec%0d.req_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            tick();
            chk_res($sformatf("vec%0d", i), vecs[i].exp_rv, vecs[i].exp_sum,
                    vecs[i].exp_tag, vecs[i].exp_cnt);
        end

        // Backpressure: result held, no ready for 3 cycles
        for (int c = 0; c < 3; c++) begin
            drive(4'b1111, 16'h4321, 16'h2222, 1'b0);
            chk($sformatf("bp%0d.req_ready", c), 32'(req_ready), 32'h0);
            tick();
            chk_res($sformatf("bp%0d", c), 1'b1, 4'd5, 2'd2, 8'd15);
        end
        // Release: accept in the same cycle as the drain
        drive(4'b1111, 16'h4321, 16'h2222, 1'b1);
        chk("bp_release.req_ready", 32'(req_ready), 32'b1000);
        tick();
        chk_res("bp_release", 1'b1, 4'd6, 2'd3, 8'd16);

        // Reach ptr = 3 with a held result, then reset mid-operation
        drive(4'b0100, 16'h0300, 16'h0400, 1'b1);
        tick();
        chk_res("pre_rst", 1'b1, 4'd7, 2'd2, 8'd17);
        rst = 1'b1;
        drive(4'b0100, 16'h0300, 16'h0400, 1'b1);
        chk("mid_rst.req_ready", 32'(req_ready), 32'h0);
        tick();
        chk_res("mid_rst", 1'b0, 4'd0, 2'd0, 8'd0);
        rst = 1'b0;
        drive(4'b1010, 16'h4321, 16'h2222, 1'b1);
        chk("post_rst.req_ready", 32'(req_ready), 32'b0010);
        tick();
        chk_res("post_rst", 1'b1, 4'd4, 2'd1, 8'd1);

        // Drain with no request: valid drops, sum/tag hold
        drive(4'b0000, 16'h0000, 16'h0000, 1'b1);
        chk("drain.req_ready", 32'(req_ready), 32'h0);
        tick();
        chk_res("drain", 1'b0, 4'd4, 2'd1, 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter that shares one 4-bit wrapping adder among four requesters. Each requester presents an operand pair under a valid/ready handshake. The granted pair is summed and held in a one-entry output register, tagged with the requester index. It sits between several client kernels and the shared adder, so the adder is instantiated exactly once in a synchronous design.

## Interface
- N, 4, number of requesters (fixed at 4; tag width is 2)
- W, 4, operand and sum width
- clock_reset  in  2  bit 0 = clock, bit 1 = reset; one clock; reset is synchronous and active-high
- req_valid  in  N  per-requester request valid
- req_a  in  N*W  operand a, requester k at bits [k*W+W-1 : k*W]
- req_b  in  N*W  operand b, same packing as req_a
- req_ready  out  N  per-requester accept; at most one bit high
- res_valid  out  1  result register holds a result
- res_sum  out  W  (a + b) mod 2^W
- res_tag  out  2  index of the requester that produced res_sum
- res_ready  in  1  downstream accepts result
- txn_count  out  8  accepted-transaction counter, wraps 255 -> 0

## Operation
- State:
  - ptr[1:0]: round-robin priority pointer.
  - Output register: res_valid, res_sum, res_tag.
  - txn_count.
- can_accept = !res_valid | res_ready (pass-through; combinational).
- Grant g = first k in the order ptr, ptr+1, ... (mod 4) with req_valid[k] = 1. If no request is valid, there is no grant.
- req_ready[g] = can_accept & grant exists & !reset. All other req_ready bits are 0.
- Accept occurs when req_valid[g] & req_ready[g]. On the clock edge:
  - res_sum <= a_g + b_g, truncated to W bits.
  - res_tag <= g; res_valid <= 1.
  - ptr <= g + 1 mod 4.
  - txn_count <= txn_count + 1.
- No accept and res_valid & res_ready: res_valid <= 0. res_sum and res_tag hold their last values.
- No accept and no drain: all state holds. ptr does not move while no request is accepted.
- Simultaneous drain and accept: the new result replaces the old one; res_valid stays 1, giving one result per cycle.
- Reset values: res_valid = 0, res_sum = 0, res_tag = 0, ptr = 0, txn_count = 0. req_ready is forced to 0 while reset is high.
- Reset mid-operation discards the held result. A requester that presented during the reset cycle is not accepted and must keep req_valid high.

## Timing
- All state updates occur on the rising edge of clock_reset[0]. Reset is sampled only at that edge.
- Latency: 1 cycle from accept edge to res_valid / res_sum.
- Throughput: 1 result per cycle when res_ready is held high.
- req_ready depends combinationally on req_valid, ptr, res_valid and res_ready. There is no combinational path from req_a or req_b to any output.
- Output register contents are stable while res_valid & !res_ready.
- Fairness: with all four requesters continuously valid, each is granted once in every 4 accepts.

## Structure
- Shared package holds:
  - Constants N = 4, W = 4, TAG_W = 2, CNT_W = 8.
  - clock_reset bit positions: CLK = 0, RST = 1.
  - The round-robin pick function (ptr, valid) -> (grant_exists, g).
- One sub-module, adder_unit: combinational W-bit wrapping add over a packed {b, a} 2W-bit input. The arbiter muxes the granted pair into it.
- The top level contains the grant logic, ptr, the output register and txn_count.

## Test plan
- Reset: hold reset 2 cycles with req_valid = 1111 -> req_ready = 0000, res_valid = 0, res_sum = 0, txn_count = 0. After release, ptr = 0, so the first grant goes to requester 0.
- Single requester 2, a = 3, b = 4, res_ready = 1 -> req_ready = 0100. Next cycle: res_valid = 1, res_sum = 7, res_tag = 2, txn_count = 1.
- Wrap: requester 0, a = 9, b = 8 -> res_sum = 1. Then a = 15, b = 15 -> res_sum = 14.
- All four valid continuously, res_ready = 1 -> res_tag sequence 0, 1, 2, 3, 0, 1 on consecutive cycles, txn_count incrementing by 1 each cycle. Repeat with requester 1 dropping after its grant -> sequence 2, 3, 0, 2.
- Backpressure: res_valid = 1 with res_ready = 0 for 3 cycles -> req_ready = 0000 and res_sum / res_tag unchanged. Raise res_ready -> a new accept in that same cycle, res_valid stays 1 and the new sum appears on the next edge.
- Reset mid-operation: with res_valid = 1 and ptr = 3, assert reset for 1 cycle -> res_valid = 0, txn_count = 0. Then with req_valid = 1010, the first grant is requester 1.
